frost_share_aggregator: RTL and testbench



---
 rtl/frost_pkg.sv | 20 ++
 rtl/mod_l_add.sv | 30 +++
 rtl/frost_share_aggregator.sv | 166 ++++++++++++++++
 tb/tb_frost_share_aggregator.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frost_pkg.sv
// Shared definitions for the FROST key-generation datapath.
//   ED25519_L           : Ed25519 group order L = 2^252 + 27742317777372353535851937790883648493
//   SCALAR_BITS_DEFAULT : default scalar width (holds L-1)
//   agg_state_e         : share-aggregator FSM states
package frost_pkg;

    localparam int SCALAR_BITS_DEFAULT = 253;

    localparam logic [SCALAR_BITS_DEFAULT-1:0] ED25519_L =
        253'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        ADD   = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } agg_state_e;

endpackage

// File: rtl/mod_l_add.sv
// Combinational modular adder: sum = (a + b) mod L, for a, b < L.
// Ports:
//   a, b : addends, each already reduced below L
//   sum  : (a + b) mod L
// Because a + b < 2L, one conditional subtraction of L is enough.
module mod_l_add
    import frost_pkg::*;
#(
    parameter int BITS = SCALAR_BITS_DEFAULT
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS-1:0] sum
);

    localparam logic [BITS:0] L_EXT = (BITS+1)'(ED25519_L);

    logic [BITS:0] raw_s;

    // One-carry-bit add followed by a single conditional subtract of L.
    always_comb begin
        raw_s = {1'b0, a} + {1'b0, b};
        if (raw_s >= L_EXT) begin
            sum = raw_s[BITS-1:0] - L_EXT[BITS-1:0];
        end else begin
            sum = raw_s[BITS-1:0];
        end
    end

endmodule

// File: rtl/frost_share_aggregator.sv
// Per-node Round-1 share aggregator. Consumes the NUM_NODES shares addressed
// to this node in sender order 0..NUM_NODES-1 and sums them modulo L.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin aggregation (accepted in IDLE/DONE/ERROR only)
//   shares_in     : packed shares, slice j from sender j
//   shares_valid  : bit j = slice j holds a valid share
//   secret_share  : sum mod L, meaningful while done=1
//   busy          : high while waiting/adding
//   done, error   : sticky completion / timeout flags, cleared by start or rst
//   missing_mask  : on error, senders not yet consumed
//   cycles        : saturating cycle count from start accept to done/error
module frost_share_aggregator
    import frost_pkg::*;
#(
    parameter int NUM_NODES      = 4,
    parameter int SCALAR_BITS    = SCALAR_BITS_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_BITS       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_NODES*SCALAR_BITS-1:0] shares_in,
    input  logic [NUM_NODES-1:0]           shares_valid,
    output logic [SCALAR_BITS-1:0]         secret_share,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [NUM_NODES-1:0]           missing_mask,
    output logic [CNT_BITS-1:0]            cycles
);

    localparam int IDX_BITS = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam logic [IDX_BITS-1:0]    IDX_LAST = IDX_BITS'(NUM_NODES - 1);
    localparam logic [CNT_BITS-1:0]    TMO_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_BITS-1:0]    CNT_MAX  = {CNT_BITS{1'b1}};
    localparam logic [SCALAR_BITS:0]   L_EXT    = (SCALAR_BITS+1)'(ED25519_L);

    agg_state_e                 state_r;
    logic [IDX_BITS-1:0]        idx_r;
    logic [SCALAR_BITS-1:0]     acc_r;
    logic [SCALAR_BITS-1:0]     share_r;
    logic [CNT_BITS-1:0]        tmo_r;
    logic [CNT_BITS-1:0]        cycles_r;
    logic [SCALAR_BITS-1:0]     secret_r;
    logic                       busy_r;
    logic                       done_r;
    logic                       error_r;
    logic [NUM_NODES-1:0]       mask_r;

    logic [SCALAR_BITS-1:0]     share_raw_s;
    logic [SCALAR_BITS-1:0]     share_red_s;
    logic [SCALAR_BITS-1:0]     add_sum_s;
    logic [NUM_NODES-1:0]       err_mask_s;
    logic [CNT_BITS-1:0]        cycles_inc_s;

    // Select the current sender's share and reduce it once: any
    // SCALAR_BITS-wide input is below 2L, so this brings it under L.
    always_comb begin
        share_raw_s = shares_in[int'(idx_r)*SCALAR_BITS +: SCALAR_BITS];
        if ({1'b0, share_raw_s} >= L_EXT) begin
            share_red_s = share_raw_s - L_EXT[SCALAR_BITS-1:0];
        end else begin
            share_red_s = share_raw_s;
        end
    end

    // Senders idx..NUM_NODES-1 are still outstanding if we give up now.
    always_comb begin
        err_mask_s = {NUM_NODES{1'b0}};
        for (int j = 0; j < NUM_NODES; j++) begin
            err_mask_s[j] = (j >= int'(idx_r));
        end
    end

    // Saturating increment of the elapsed-cycle counter.
    always_comb begin
        if (cycles_r == CNT_MAX) begin
            cycles_inc_s = cycles_r;
        end else begin
            cycles_inc_s = cycles_r + CNT_BITS'(1);
        end
    end

    mod_l_add #(
        .BITS (SCALAR_BITS)
    ) u_mod_l_add (
        .a   (acc_r),
        .b   (share_r),
        .sum (add_sum_s)
    );

    // Aggregation FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            idx_r    <= {IDX_BITS{1'b0}};
            acc_r    <= {SCALAR_BITS{1'b0}};
            share_r  <= {SCALAR_BITS{1'b0}};
            tmo_r    <= {CNT_BITS{1'b0}};
            cycles_r <= {CNT_BITS{1'b0}};
            secret_r <= {SCALAR_BITS{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
            mask_r   <= {NUM_NODES{1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_r  <= WAIT;
                        idx_r    <= {IDX_BITS{1'b0}};
                        acc_r    <= {SCALAR_BITS{1'b0}};
                        tmo_r    <= {CNT_BITS{1'b0}};
                        cycles_r <= {CNT_BITS{1'b0}};
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
                        error_r  <= 1'b0;
                        mask_r   <= {NUM_NODES{1'b0}};
                    end
                end
                WAIT: begin
                    cycles_r <= cycles_inc_s;
                    if (shares_valid[idx_r]) begin
                        share_r <= share_red_s;
                        tmo_r   <= {CNT_BITS{1'b0}};
                        state_r <= ADD;
                    end else if (tmo_r == TMO_LAST) begin
                        state_r <= ERROR;
                        busy_r  <= 1'b0;
                        error_r <= 1'b1;
                        mask_r  <= err_mask_s;
                    end else begin
                        tmo_r <= tmo_r + CNT_BITS'(1);
                    end
                end
                ADD: begin
                    cycles_r <= cycles_inc_s;
                    acc_r    <= add_sum_s;
                    if (idx_r == IDX_LAST) begin
                        state_r  <= DONE;
                        secret_r <= add_sum_s;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                    end else begin
                        idx_r   <= idx_r + IDX_BITS'(1);
                        state_r <= WAIT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign secret_share = secret_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign missing_mask = mask_r;
    assign cycles       = cycles_r;

endmodule

// File: tb/tb_frost_share_aggregator.sv
// Self-checking bench for frost_share_aggregator. Two instances share the
// clock and reset: u_dut0 with the default timeout, u_dut1 with a short one.
module tb_frost_share_aggregator;
    import frost_pkg::*;

    localparam int N     = 4;
    localparam int SB    = 253;
    localparam int CB    = 16;
    localparam int T0    = 1024;
    localparam int T1    = 16;
    localparam int NEVER = 1000000;
    localparam logic [SB-1:0] LL = ED25519_L;

    logic clk = 1'b0;
    logic rst;

    logic            start_s  [2];
    logic [N*SB-1:0] shares_s [2];
    logic [N-1:0]    valid_s  [2];
    logic [SB-1:0]   secret_s [2];
    logic            busy_s   [2];
    logic            done_s   [2];
    logic            error_s  [2];
    logic [N-1:0]    mask_s   [2];
    logic [CB-1:0]   cycles_s [2];

    always #5 clk = ~clk;

    frost_share_aggregator #(.NUM_NODES(N), .SCALAR_BITS(SB), .TIMEOUT_CYCLES(T0), .CNT_BITS(CB)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .shares_in(shares_s[0]), .shares_valid(valid_s[0]),
        .secret_share(secret_s[0]), .busy(busy_s[0]), .done(done_s[0]), .error(error_s[0]),
        .missing_mask(mask_s[0]), .cycles(cycles_s[0]));

    frost_share_aggregator #(.NUM_NODES(N), .SCALAR_BITS(SB), .TIMEOUT_CYCLES(T1), .CNT_BITS(CB)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .shares_in(shares_s[1]), .shares_valid(valid_s[1]),
        .secret_share(secret_s[1]), .busy(busy_s[1]), .done(done_s[1]), .error(error_s[1]),
        .missing_mask(mask_s[1]), .cycles(cycles_s[1]));

    int checks = 0;
    int errors = 0;

    // Current transaction: shares, arrival cycle of each valid bit relative
    // to the start cycle (0), and an optional cycle to pulse start while busy.
    logic [SB-1:0] cur_sh  [N];
    int            cur_arr [N];
    int            poke;
    int            obs_seen;
    logic [SB-1:0] obs_sum;

    typedef struct {
        logic [N-1:0][SB-1:0] sh;
        logic [N-1:0][15:0]   arr;
        int                   poke;
        logic [SB-1:0]        exp_sum;
        int                   exp_lat;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [SB-1:0] act, input logic [SB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one transaction on instance d and compare against the reference
    // model: sender j is taken at max(arrival, ready), the next sender is
    // ready two cycles later, and a sender left waiting T cycles is a timeout.
    task automatic txn(input int d, input string name);
        int            t;
        int            ready;
        int            cons;
        bit            ok;
        int            exp_cyc;
        logic [N-1:0]  exp_mask;
        logic [SB+8:0] wide;
        logic [SB-1:0] exp_sum;
        int            seen;

        t        = (d == 0) ? T0 : T1;
        ready    = 1;
        ok       = 1'b1;
        exp_cyc  = 0;
        exp_mask = '0;
        for (int j = 0; j < N; j++) begin
            if (ok) begin
                if (cur_arr[j] - ready >= t) begin
                    ok      = 1'b0;
                    exp_cyc = ready + t;
                    for (int m = j; m < N; m++) exp_mask[m] = 1'b1;
                end else begin
                    cons  = (cur_arr[j] > ready) ? cur_arr[j] : ready;
                    ready = cons + 2;
                end
            end
        end
        if (ok) exp_cyc = ready;
        wide = '0;
        for (int j = 0; j < N; j++) wide = wide + {9'd0, cur_sh[j]};
        wide    = wide % {9'd0, LL};
        exp_sum = wide[SB-1:0];

        for (int j = 0; j < N; j++) begin
            shares_s[d][j*SB +: SB] = cur_sh[j];
            valid_s[d][j]           = (cur_arr[j] <= 0);
        end
        start_s[d] = 1'b1;
        step();
        start_s[d] = 1'b0;
        seen = -1;
        for (int k = 1; k <= 4000; k++) begin
            if (k == 1) begin
                check({name, " busy@1"}, SB'(busy_s[d]), SB'(1));
                check({name, " flags cleared@1"}, SB'({done_s[d], error_s[d]}), SB'(0));
            end
            if (done_s[d] || error_s[d]) begin
                seen = k;
                break;
            end
            for (int j = 0; j < N; j++) valid_s[d][j] = (cur_arr[j] <= k);
            start_s[d] = (k == poke);
            step();
        end
        start_s[d] = 1'b0;
        if (seen < 0) $display("FAIL %s timeout: no done/error within 4000 cycles", name);
        obs_seen = seen;
        obs_sum  = secret_s[d];
        check({name, " latency"}, SB'(seen), SB'(exp_cyc));
        check({name, " done"}, SB'(done_s[d]), SB'(ok));
        check({name, " error"}, SB'(error_s[d]), SB'(!ok));
        check({name, " busy"}, SB'(busy_s[d]), SB'(0));
        check({name, " cycles"}, SB'(cycles_s[d]), SB'(exp_cyc - 1));
        if (ok) check({name, " secret_share"}, secret_s[d], exp_sum);
        else    check({name, " missing_mask"}, SB'(mask_s[d]), SB'(exp_mask));
    endtask

    task automatic check_zero(input int d, input string name);
        check({name, " secret_share"}, secret_s[d], SB'(0));
        check({name, " flags"}, SB'({busy_s[d], done_s[d], error_s[d]}), SB'(0));
        check({name, " missing_mask"}, SB'(mask_s[d]), SB'(0));
        check({name, " cycles"}, SB'(cycles_s[d]), SB'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] rnd;
        int           mode;

        // Table: shares (element 0 rightmost), arrivals, poke, expected sum, latency.
        tbl[0] = '{sh: {SB'(4), SB'(3), SB'(2), SB'(1)}, arr: '0, poke: 0, exp_sum: SB'(10), exp_lat: 9};
        tbl[1] = '{sh: {SB'(0), SB'(1), LL - SB'(1), LL - SB'(1)}, arr: '0, poke: 0, exp_sum: LL - SB'(1), exp_lat: 9};
        tbl[2] = '{sh: {SB'(0), SB'(0), SB'(0), LL + SB'(5)}, arr: '0, poke: 0, exp_sum: SB'(5), exp_lat: 9};
        tbl[3] = '{sh: {SB'(10), SB'(9), SB'(8), SB'(7)}, arr: {16'd1, 16'd11, 16'd21, 16'd31}, poke: 0,
                   exp_sum: SB'(34), exp_lat: 39};
        tbl[4] = '{sh: {SB'(8), SB'(7), SB'(6), SB'(5)}, arr: '0, poke: 4, exp_sum: SB'(26), exp_lat: 9};

        rst = 1'b1;
        poke = 0;
        for (int d = 0; d < 2; d++) begin
            start_s[d]  = 1'b0;
            shares_s[d] = '0;
            valid_s[d]  = '0;
        end
        step();
        step();
        check_zero(0, "reset dut0");
        check_zero(1, "reset dut1");
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < N; j++) begin
                cur_sh[j]  = tbl[i].sh[j];
                cur_arr[j] = int'(tbl[i].arr[j]);
            end
            poke = tbl[i].poke;
            txn(0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table sum", i), obs_sum, tbl[i].exp_sum);
            check($sformatf("vec%0d table latency", i), SB'(obs_seen), SB'(tbl[i].exp_lat));
            step();
        end
        poke = 0;

        // Timeout on sender 2 with the short-timeout instance, then recovery.
        for (int j = 0; j < N; j++) begin
            cur_sh[j]  = SB'(j + 1);
            cur_arr[j] = (j == 2) ? NEVER : 0;
        end
        txn(1, "timeout");
        check("timeout mask literal", SB'(mask_s[1]), SB'(4'b1100));
        check("timeout latency literal", SB'(obs_seen), SB'(21));
        step();
        for (int j = 0; j < N; j++) cur_arr[j] = 0;
        txn(1, "recover");
        step();

        // Reset while adding sender 1 (cycle 4 after start), then a clean run.
        for (int j = 0; j < N; j++) begin
            cur_sh[j] = SB'(11 * (j + 1));
            shares_s[0][j*SB +: SB] = cur_sh[j];
        end
        valid_s[0] = '1;
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero(0, "midrst");
        for (int j = 0; j < N; j++) begin
            cur_sh[j]  = SB'(j + 1);
            cur_arr[j] = 0;
        end
        txn(0, "post-reset");
        check("post-reset sum literal", obs_sum, SB'(10));
        step();

        // Randomised transactions on the short-timeout instance.
        for (int r = 0; r < 20; r++) begin
            for (int j = 0; j < N; j++) begin
                rnd  = {$urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom()};
                mode = $urandom_range(0, 3);
                case (mode)
                    0:       cur_sh[j] = rnd[SB-1:0];
                    1:       cur_sh[j] = LL - SB'($urandom_range(1, 8));
                    2:       cur_sh[j] = LL + SB'($urandom_range(0, 8));
                    default: cur_sh[j] = SB'($urandom_range(0, 1000));
                endcase
                cur_arr[j] = $urandom_range(0, 24);
            end
            txn(1, $sformatf("rand%0d", r));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
